// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, parity modes, parity helper.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Expected parity bit for a data word. Bits above the configured width must
  // be zero so they do not disturb the XOR reduction.
  function automatic logic exp_parity(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Receiver output bundle: received word, status flags, frame strobe and busy.
// Latency: n/a (wiring only).
// Backpressure: none; o_Rx_DV is a one-cycle strobe the consumer must catch.
interface uart_rx_ext_if #(
  parameter int DATA_BITS = 8
);
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Busy;

  modport master (
    output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
  );

  modport slave (
    input o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Serial line front end: 2-flop synchroniser plus a 3-tap history for majority voting.
// Latency: rx_s lags i_Rx_Serial by 2 clocks; rx_maj votes over rx_s now and the 2 previous cycles.
// Backpressure: none.
// Ports: i_Clock/i_Reset (sync, active-high), i_Rx_Serial (async line),
//        rx_s (synchronised line), rx_maj (majority of the last three rx_s values).
module uart_rx_sampler (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Rx_Serial,
  output logic rx_s,
  output logic rx_maj
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic tap0_q, tap0_d;
  logic tap1_q, tap1_d;

  always_comb begin
    sync1_d = i_Rx_Serial;
    sync2_d = sync1_q;
    tap0_d  = sync2_q;
    tap1_d  = tap0_q;
  end

  // Everything resets to the idle-high line level so no false start appears.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tap0_q  <= 1'b1;
      tap1_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      tap0_q  <= tap0_d;
      tap1_q  <= tap1_d;
    end
  end

  assign rx_s = sync2_q;

  // When the bit counter sits at MID+1, the taps hold the samples from MID and
  // MID-1, so this vote covers exactly the three centre samples of the bit.
  assign rx_maj = (rx_s & tap0_q) | (rx_s & tap1_q) | (tap0_q & tap1_q);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: DATA_BITS LSB-first, optional odd/even parity, 1-2 stop bits, break detect.
// Latency: o_Rx_DV rises (F-1)*CLKS_PER_BIT + MID + 2 clocks after leaving IDLE, F = bits per frame.
// Backpressure: none; one o_Rx_DV pulse per frame, data and flags hold until the next pulse.
// Ports: i_Clock, i_Reset (sync, active-high), i_Rx_Serial (idle high),
//        rx_if.master carries o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy.
module uart_rx_ext #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  input  logic           i_Rx_Serial,
  uart_rx_ext_if.master  rx_if
);
  import uart_pkg::*;

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] EVAL_CNT  = CW'(MID + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  logic rx_s;
  logic rx_maj;

  uart_rx_sampler u_sampler (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (i_Rx_Serial),
    .rx_s        (rx_s),
    .rx_maj      (rx_maj)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] data_sh_q, data_sh_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_sh_q, perr_sh_d;
  logic                 ferr_sh_q, ferr_sh_d;

  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;

  logic                 cnt_wrap;
  logic                 at_eval;
  logic                 ferr_now;
  logic [8:0]           par_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_sh_d = data_sh_q;
    par_bit_d = par_bit_q;
    perr_sh_d = perr_sh_q;
    ferr_sh_d = ferr_sh_q;
    dv_d      = 1'b0;
    byte_d    = byte_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;

    cnt_wrap = (cnt_q == LAST_CNT);
    at_eval  = (cnt_q == EVAL_CNT);
    // Frame error including the stop bit being evaluated this cycle.
    ferr_now = ferr_sh_q | ~rx_maj;

    par_data = '0;
    par_data[DATA_BITS-1:0] = data_sh_q;

    if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d   = ST_START;
          data_sh_d = '0;
          par_bit_d = 1'b0;
          perr_sh_d = 1'b0;
          ferr_sh_d = 1'b0;
        end
      end

      ST_START: begin
        if (at_eval && rx_maj) begin
          state_d = ST_IDLE;            // too short to be a start bit
        end else if (cnt_wrap) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end

      ST_DATA: begin
        // LSB arrives first, so shifting in from the top leaves the word
        // aligned after the last data bit.
        if (at_eval) begin
          data_sh_d = {rx_maj, data_sh_q[DATA_BITS-1:1]};
        end
        if (cnt_wrap) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (at_eval) begin
          par_bit_d = rx_maj;
          perr_sh_d = (rx_maj != exp_parity(par_data, PARITY_MODE));
        end
        if (cnt_wrap) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
        end
      end

      ST_STOP: begin
        if (at_eval) begin
          ferr_sh_d = ferr_now;
          // Finish at the centre of the last stop bit; the remaining half bit
          // is slack for baud-rate mismatch.
          if (bit_idx_q == LAST_STOP) begin
            state_d = ST_DONE;
            dv_d    = 1'b1;
            byte_d  = data_sh_q;
            perr_d  = perr_sh_q;
            ferr_d  = ferr_now;
            brk_d   = ferr_now && (data_sh_q == '0) &&
                      ((PARITY_MODE == PARITY_NONE) || !par_bit_q);
          end
        end else if (cnt_wrap) begin
          bit_idx_d = bit_idx_q + BW'(1);
        end
      end

      ST_DONE: begin
        cnt_d   = '0;
        // A low line after a bad stop bit is a held break: wait for it to end.
        state_d = ferr_sh_q ? ST_WAIT_HIGH : ST_IDLE;
      end

      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_sh_q <= '0;
      par_bit_q <= 1'b0;
      perr_sh_q <= 1'b0;
      ferr_sh_q <= 1'b0;
      dv_q      <= 1'b0;
      byte_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_sh_q <= data_sh_d;
      par_bit_q <= par_bit_d;
      perr_sh_q <= perr_sh_d;
      ferr_sh_q <= ferr_sh_d;
      dv_q      <= dv_d;
      byte_q    <= byte_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
    end
  end

  assign rx_if.o_Rx_DV      = dv_q;
  assign rx_if.o_Rx_Byte    = byte_q;
  assign rx_if.o_Parity_Err = perr_q;
  assign rx_if.o_Frame_Err  = ferr_q;
  assign rx_if.o_Break      = brk_q;
  assign rx_if.o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Testbench for uart_rx_ext: three receiver configurations (8N1, 7E2, 8O1) at 16 clocks per bit.
// Directed scenarios plus randomized frames checked against a frame-level reference model.
// Each DV pulse is captured with its latency from the busy rising edge.
`timescale 1ns/1ps
module tb_uart_rx_ext;

  localparam int CPB = 16;
  localparam int MID = (CPB - 1) / 2;

  int cfg_db[3] = '{8, 7, 8};
  int cfg_pm[3] = '{0, 2, 1};
  int cfg_sb[3] = '{1, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ser[3] = '{1'b1, 1'b1, 1'b1};

  uart_rx_ext_if #(.DATA_BITS(8)) if_a ();
  uart_rx_ext_if #(.DATA_BITS(7)) if_b ();
  uart_rx_ext_if #(.DATA_BITS(8)) if_c ();

  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(ser[0]), .rx_if(if_a.master));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(ser[1]), .rx_if(if_b.master));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(ser[2]), .rx_if(if_c.master));

  logic       dv_w[3], busy_w[3], pe_w[3], fe_w[3], brk_w[3];
  logic [8:0] byte_w[3];

  always_comb begin
    dv_w[0] = if_a.o_Rx_DV; busy_w[0] = if_a.o_Busy; pe_w[0] = if_a.o_Parity_Err;
    fe_w[0] = if_a.o_Frame_Err; brk_w[0] = if_a.o_Break; byte_w[0] = {1'b0, if_a.o_Rx_Byte};
    dv_w[1] = if_b.o_Rx_DV; busy_w[1] = if_b.o_Busy; pe_w[1] = if_b.o_Parity_Err;
    fe_w[1] = if_b.o_Frame_Err; brk_w[1] = if_b.o_Break; byte_w[1] = {2'b00, if_b.o_Rx_Byte};
    dv_w[2] = if_c.o_Rx_DV; busy_w[2] = if_c.o_Busy; pe_w[2] = if_c.o_Parity_Err;
    fe_w[2] = if_c.o_Frame_Err; brk_w[2] = if_c.o_Break; byte_w[2] = {1'b0, if_c.o_Rx_Byte};
  end

  typedef struct {
    int         dut;
    int         cyc;
    int         lat;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } dv_rec_t;

  dv_rec_t cap_q[$];
  dv_rec_t exp_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rise_cyc[3] = '{0, 0, 0};
  logic busy_prev[3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every DV pulse away from the active edge.
  always @(negedge clk) begin : monitor
    dv_rec_t r;
    for (int i = 0; i < 3; i++) begin
      if (busy_w[i] === 1'b1 && busy_prev[i] !== 1'b1) rise_cyc[i] = cyc;
      busy_prev[i] = busy_w[i];
      if (dv_w[i] === 1'b1) begin
        r.dut  = i;
        r.cyc  = cyc;
        r.lat  = cyc - rise_cyc[i];
        r.data = byte_w[i];
        r.pe   = pe_w[i];
        r.fe   = fe_w[i];
        r.brk  = brk_w[i];
        cap_q.push_back(r);
      end
    end
  end

  // ---------------- reference model (frame level) ----------------
  function automatic int exp_lat(input int d);
    int f;
    f = 1 + cfg_db[d] + ((cfg_pm[d] != 0) ? 1 : 0) + cfg_sb[d];
    return (f - 1) * CPB + MID + 2;
  endfunction

  // Parity bit a correct transmitter would send for this word.
  function automatic logic good_parity(input int d, input logic [8:0] data);
    int ones;
    ones = 0;
    for (int i = 0; i < cfg_db[d]; i++) ones += int'(data[i]);
    if (cfg_pm[d] == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic dv_rec_t model(input int d, input logic [8:0] data, input logic par_bit,
                                    input logic [1:0] stops);
    dv_rec_t r;
    logic [8:0] m;
    m      = 9'((1 << cfg_db[d]) - 1);
    r.dut  = d;
    r.cyc  = 0;
    r.lat  = exp_lat(d);
    r.data = data & m;
    r.pe   = (cfg_pm[d] != 0) && (par_bit != good_parity(d, data));
    r.fe   = (stops[0] == 1'b0) || (cfg_sb[d] == 2 && stops[1] == 1'b0);
    r.brk  = r.fe && (r.data == 9'd0) && (cfg_pm[d] == 0 || par_bit == 1'b0);
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_bit(input int d, input logic v, input int n);
    ser[d] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stops);
    drive_bit(d, 1'b0, CPB);
    for (int i = 0; i < cfg_db[d]; i++) drive_bit(d, data[i], CPB);
    if (cfg_pm[d] != 0) drive_bit(d, par_bit, CPB);
    for (int i = 0; i < cfg_sb[d]; i++) drive_bit(d, stops[i], CPB);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({dv_w[d], byte_w[d], pe_w[d], fe_w[d], brk_w[d], busy_w[d]} !== 14'd0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got dv=%b byte=%h pe=%b fe=%b brk=%b busy=%b want all 0",
                 d, dv_w[d], byte_w[d], pe_w[d], fe_w[d], brk_w[d], busy_w[d]);
      end
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_8n1;
    cap_q.delete();
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    idle(3 * CPB);
    total++;
    if (cap_q.size() != 1) begin
      bad++; $display("FAIL basic_count: got %0d want 1", cap_q.size());
    end else begin
      total++;
      if (cap_q[0].data !== 9'h0A5) begin
        bad++; $display("FAIL basic_byte: got %h want a5", cap_q[0].data);
      end
      total++;
      if ({cap_q[0].pe, cap_q[0].fe, cap_q[0].brk} !== 3'b000) begin
        bad++; $display("FAIL basic_flags: got pe/fe/brk=%b%b%b want 000", cap_q[0].pe, cap_q[0].fe, cap_q[0].brk);
      end
      total++;
      if (cap_q[0].lat != exp_lat(0)) begin
        bad++; $display("FAIL basic_latency: got %0d want %0d", cap_q[0].lat, exp_lat(0));
      end
    end
  endtask

  task automatic test_parity_7e2;
    cap_q.delete();
    send_frame(1, 9'h041, 1'b0, 2'b11);
    idle(CPB);
    send_frame(1, 9'h041, 1'b1, 2'b11);
    idle(3 * CPB);
    total++;
    if (cap_q.size() != 2) begin
      bad++; $display("FAIL parity_count: got %0d want 2", cap_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (cap_q[k].dut != 1 || cap_q[k].data !== 9'h041) begin
          bad++; $display("FAIL parity_byte%0d: got dut%0d %h want dut1 41", k, cap_q[k].dut, cap_q[k].data);
        end
        total++;
        if (cap_q[k].pe !== (k == 1) || cap_q[k].fe !== 1'b0) begin
          bad++; $display("FAIL parity_err%0d: got pe=%b fe=%b want pe=%0d fe=0", k, cap_q[k].pe, cap_q[k].fe, k);
        end
      end
      total++;
      if (cap_q[0].lat != exp_lat(1)) begin
        bad++; $display("FAIL parity_latency: got %0d want %0d", cap_q[0].lat, exp_lat(1));
      end
    end
  endtask

  task automatic test_glitch;
    logic [7:0] d8;
    d8 = 8'h3C;
    cap_q.delete();
    drive_bit(0, 1'b0, 3);            // short start glitch
    drive_bit(0, 1'b1, 2 * CPB);
    total++;
    if (cap_q.size() != 0) begin
      bad++; $display("FAIL glitch_start_dv: got %0d pulses want 0", cap_q.size());
    end
    drive_bit(0, 1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        drive_bit(0, 1'b1, 8);
        drive_bit(0, 1'b0, 1);        // one-clock dip at bit centre
        drive_bit(0, 1'b1, CPB - 9);
      end else begin
        drive_bit(0, d8[i], CPB);
      end
    end
    drive_bit(0, 1'b1, CPB);
    idle(2 * CPB);
    total++;
    if (cap_q.size() != 1) begin
      bad++; $display("FAIL glitch_count: got %0d want 1", cap_q.size());
    end else begin
      total++;
      if (cap_q[0].data !== 9'h03C || {cap_q[0].pe, cap_q[0].fe, cap_q[0].brk} !== 3'b000) begin
        bad++; $display("FAIL glitch_byte: got %h flags %b%b%b want 3c flags 000",
                        cap_q[0].data, cap_q[0].pe, cap_q[0].fe, cap_q[0].brk);
      end
      total++;
      if (cap_q[0].lat != exp_lat(0)) begin
        bad++; $display("FAIL glitch_latency: got %0d want %0d", cap_q[0].lat, exp_lat(0));
      end
    end
  endtask

  task automatic test_break;
    cap_q.delete();
    drive_bit(0, 1'b0, 30 * CPB);
    total++;
    if (cap_q.size() != 1) begin
      bad++; $display("FAIL break_count: got %0d want 1", cap_q.size());
    end else begin
      total++;
      if (cap_q[0].data !== 9'h000 || {cap_q[0].pe, cap_q[0].fe, cap_q[0].brk} !== 3'b011) begin
        bad++; $display("FAIL break_flags: got %h pe/fe/brk=%b%b%b want 00 011",
                        cap_q[0].data, cap_q[0].pe, cap_q[0].fe, cap_q[0].brk);
      end
    end
    total++;
    if (busy_w[0] !== 1'b1) begin
      bad++; $display("FAIL break_busy_low_line: got %b want 1", busy_w[0]);
    end
    drive_bit(0, 1'b1, 2 * CPB);
    total++;
    if (cap_q.size() != 1 || busy_w[0] !== 1'b0) begin
      bad++; $display("FAIL break_release: got %0d pulses busy=%b want 1 busy=0", cap_q.size(), busy_w[0]);
    end
    send_frame(0, 9'h055, 1'b0, 2'b11);
    idle(2 * CPB);
    total++;
    if (cap_q.size() != 2) begin
      bad++; $display("FAIL break_next_count: got %0d want 2", cap_q.size());
    end else begin
      total++;
      if (cap_q[1].data !== 9'h055 || {cap_q[1].pe, cap_q[1].fe, cap_q[1].brk} !== 3'b000) begin
        bad++; $display("FAIL break_next_byte: got %h flags %b%b%b want 55 000",
                        cap_q[1].data, cap_q[1].pe, cap_q[1].fe, cap_q[1].brk);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    cap_q.delete();
    fork
      send_frame(0, 9'h0FF, 1'b0, 2'b11);
      begin
        idle(4 * CPB);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        total++;
        if ({dv_w[0], byte_w[0], pe_w[0], fe_w[0], brk_w[0], busy_w[0]} !== 14'd0) begin
          bad++;
          $display("FAIL midreset_outputs: got byte=%h pe=%b fe=%b brk=%b busy=%b want all 0",
                   byte_w[0], pe_w[0], fe_w[0], brk_w[0], busy_w[0]);
        end
      end
    join
    idle(2 * CPB);
    total++;
    if (cap_q.size() != 0) begin
      bad++; $display("FAIL midreset_no_dv: got %0d pulses want 0", cap_q.size());
    end
    send_frame(0, 9'h012, 1'b0, 2'b11);
    idle(2 * CPB);
    total++;
    if (cap_q.size() != 1) begin
      bad++; $display("FAIL midreset_next_count: got %0d want 1", cap_q.size());
    end else begin
      total++;
      if (cap_q[0].data !== 9'h012 || {cap_q[0].pe, cap_q[0].fe, cap_q[0].brk} !== 3'b000) begin
        bad++; $display("FAIL midreset_next_byte: got %h flags %b%b%b want 12 000",
                        cap_q[0].data, cap_q[0].pe, cap_q[0].fe, cap_q[0].brk);
      end
    end
  endtask

  task automatic test_back_to_back;
    cap_q.delete();
    send_frame(2, 9'h000, good_parity(2, 9'h000), 2'b11);
    send_frame(2, 9'h0FF, good_parity(2, 9'h0FF), 2'b11);
    idle(2 * CPB);
    total++;
    if (cap_q.size() != 2) begin
      bad++; $display("FAIL b2b_count: got %0d want 2", cap_q.size());
    end else begin
      total++;
      if (cap_q[1].cyc - cap_q[0].cyc != 11 * CPB) begin
        bad++; $display("FAIL b2b_spacing: got %0d want %0d", cap_q[1].cyc - cap_q[0].cyc, 11 * CPB);
      end
      total++;
      if (cap_q[0].data !== 9'h000 || cap_q[1].data !== 9'h0FF) begin
        bad++; $display("FAIL b2b_bytes: got %h %h want 00 ff", cap_q[0].data, cap_q[1].data);
      end
      total++;
      if ({cap_q[0].pe, cap_q[0].fe, cap_q[0].brk, cap_q[1].pe, cap_q[1].fe, cap_q[1].brk} !== 6'd0) begin
        bad++; $display("FAIL b2b_flags: got %b%b%b %b%b%b want 000 000", cap_q[0].pe, cap_q[0].fe,
                        cap_q[0].brk, cap_q[1].pe, cap_q[1].fe, cap_q[1].brk);
      end
    end
  endtask

  task automatic test_random;
    logic [8:0] data;
    logic       pb;
    logic [1:0] stops;
    dv_rec_t    e;
    int         gap;
    for (int d = 0; d < 3; d++) begin
      cap_q.delete();
      exp_q.delete();
      for (int n = 0; n < 8; n++) begin
        data  = 9'($urandom);
        if ($urandom_range(3) == 0) data = 9'd0;
        pb    = good_parity(d, data) ^ ($urandom_range(3) == 0);
        stops = ($urandom_range(3) == 0) ? 2'($urandom_range(2)) : 2'b11;
        e = model(d, data, pb, stops);
        exp_q.push_back(e);
        send_frame(d, data, pb, stops);
        if (e.fe) gap = $urandom_range(4, CPB);
        else      gap = ($urandom_range(2) == 0) ? 0 : $urandom_range(1, CPB);
        if (gap > 0) drive_bit(d, 1'b1, gap);
      end
      drive_bit(d, 1'b1, 2 * CPB);
      total++;
      if (cap_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand_count dut%0d: got %0d want %0d", d, cap_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          total++;
          if (cap_q[k].dut != d || cap_q[k].data !== exp_q[k].data || cap_q[k].pe !== exp_q[k].pe ||
              cap_q[k].fe !== exp_q[k].fe || cap_q[k].brk !== exp_q[k].brk || cap_q[k].lat != exp_q[k].lat) begin
            bad++;
            $display("FAIL rand_frame dut%0d #%0d: got dut%0d %h pe=%b fe=%b brk=%b lat=%0d want %h pe=%b fe=%b brk=%b lat=%0d",
                     d, k, cap_q[k].dut, cap_q[k].data, cap_q[k].pe, cap_q[k].fe, cap_q[k].brk, cap_q[k].lat,
                     exp_q[k].data, exp_q[k].pe, exp_q[k].fe, exp_q[k].brk, exp_q[k].lat);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity_7e2();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
- Parametrised UART receiver; next generation of the fixed 8N1 receiver.
- Adds configurable data width, optional odd/even parity and 1 or 2 stop bits.
- Adds 3-sample majority voting per bit, plus parity-error, framing-error and break detection.
- Sits between the board RX pin and the command/byte-consumer logic; one byte per o_Rx_DV pulse.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit period (>=8)
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits expected (1 or 2)

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous reset, active-high
i_Rx_Serial  in  1  asynchronous serial line, idle high
o_Rx_DV  out  1  one-cycle pulse: frame complete, outputs below valid
o_Rx_Byte  out  DATA_BITS  received data
o_Parity_Err  out  1  parity mismatch on the last frame (0 when PARITY_MODE=0)
o_Frame_Err  out  1  a stop bit sampled low on the last frame
o_Break  out  1  last frame all-zero, including parity and stop bits
o_Busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (i_Clock edge with i_Reset=1):
  - state IDLE; o_Rx_DV, o_Rx_Byte and all flags = 0.
  - Both synchroniser flops = 1; counters = 0.
  - Reset mid-frame aborts the frame silently; no DV.
- Input: 2-flop synchroniser, output rx_s.
- Sampling:
  - MID = (CLKS_PER_BIT-1)/2.
  - Samples are taken at bit counts MID-1, MID and MID+1; the bit value is the majority of the three.
  - Evaluation happens at count MID+1.
  - Bit counter runs 0..CLKS_PER_BIT-1, then wraps to 0 and advances to the next bit.
- States: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH.
- IDLE: counters cleared. rx_s==0 -> START with count=0.
- START: at MID+1, majority 0 -> continue; majority 1 -> IDLE (glitch rejected, no DV).
- DATA: majority bit written to o_Rx_Byte index bit_idx (internal shadow register). After bit DATA_BITS-1 -> PARITY if PARITY_MODE!=0, else STOP.
- PARITY: compare the majority bit with the expected value.
  - Odd mode: expected = ~^data.
  - Even mode: expected = ^data.
- STOP:
  - Any stop bit with majority 0 sets frame_err.
  - After evaluating the final stop bit at MID+1, go to DONE immediately, without waiting for the end of the bit. This half-bit slack absorbs baud mismatch.
- DONE (one cycle):
  - o_Rx_DV=1; o_Rx_Byte, o_Parity_Err, o_Frame_Err and o_Break take the shadow values.
  - o_Break = frame_err AND data==0 AND (no parity OR parity bit==0).
  - Next state: WAIT_HIGH if frame_err, else IDLE.
- WAIT_HIGH: stay until rx_s==1, then IDLE. This prevents a held break from retriggering repeatedly.
- Data and flags hold their values until the next DV; DV is never asserted for more than one cycle.
- Latency:
  - F = 1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS.
  - DV rises (F-1)*CLKS_PER_BIT + MID + 2 cycles after the IDLE->START transition.
- Back-to-back frames: a start edge arriving right after DONE is accepted; no idle gap is required beyond the stop bit(s).

Decomposition:
- Package uart_pkg holds:
  - state encodings (3-bit);
  - PARITY_NONE/ODD/EVEN constants;
  - a function for the expected parity bit.
- Sub-module uart_rx_sampler: 2-flop synchroniser plus 3-tap majority register, shared with future receivers.

Test Plan:
1. CLKS_PER_BIT=16, 8N1, send 0xA5 -> one DV pulse at the computed latency ±0; o_Rx_Byte=0xA5; all flags 0.
2. DATA_BITS=7, even parity, 2 stop bits; send 0x41 with correct parity (0), then with parity bit 1 -> o_Rx_Byte=0x41 in both cases; o_Parity_Err 0, then 1.
3. Frame 0x3C with a 1-clock low glitch at the centre of data bit 2 (value 1), plus a 3-clock start glitch before the frame:
   - majority vote keeps bit 2 = 1, so o_Rx_Byte=0x3C;
   - the start glitch produces no DV.
4. Hold line low for 3 frame times (8N1) -> exactly one DV with o_Rx_Byte=0x00, o_Frame_Err=1, o_Break=1. No further DV until the line returns high. A following valid 0x55 is received cleanly.
5. Assert i_Reset for one cycle mid-data of frame 0xFF -> no DV; outputs 0; o_Busy=0. The next full frame 0x12 is received correctly.
6. Two back-to-back 8O1 frames 0x00 and 0xFF with no idle gap -> two DVs exactly 11*CLKS_PER_BIT apart; both bytes correct; o_Parity_Err=0.
